// File: rtl/spi_master.sv
// spi_master -- single-slave SPI master issuing 16-bit frames:
// a command byte {addr[6:0], rw} followed by a data byte, both MSB first.
// SPI mode 0: sclk idles low, mosi changes at the start of the low phase,
// and the slave samples on the sclk rising edge.
//
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   start          : transaction request, sampled only in IDLE
//   rw             : 1 = read, 0 = write (captured with start)
//   addr[6:0]      : target address (captured with start)
//   wdata[7:0]     : write data (captured with start)
//   busy           : frame or post-frame gap in progress
//   done           : one-cycle pulse when cs_pin rises at frame end
//   rdata[7:0]     : last read result, held until the next read
//   sclk_pin, cs_pin, mosi_pin, miso_pin : SPI pins (cs_pin active low)
//
// Parameter CLK_DIV: clk cycles per sclk half-period (2..255).
// Macro SPIM_CS_GUARD_EN: when defined, adds CLK_DIV-cycle SETUP and HOLD
// states with cs low and sclk low around the 16 bit periods.
module spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

`ifdef SPIM_CS_GUARD_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHIFT, GAP} state_t;
`endif

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state, state_n;
  logic [8:0]  cnt, cnt_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [15:0] tx, tx_n;
  logic [7:0]  rx, rx_n;
  logic        rd, rd_n;
  logic        sclk_n, cs_n, mosi_n, busy_n, done_n;
  logic [7:0]  rdata_n;
  logic        fin;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    rx_n      = rx;
    rd_n      = rd;
    sclk_n    = sclk_pin;
    cs_n      = cs_pin;
    mosi_n    = mosi_pin;
    busy_n    = busy;
    done_n    = 1'b0;
    rdata_n   = rdata;
    fin       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          rd_n      = rw;
          tx_n      = {addr, rw, (rw ? 8'h00 : wdata)};
          cs_n      = 1'b0;
          busy_n    = 1'b1;
          sclk_n    = 1'b0;
          cnt_n     = '0;
          bit_cnt_n = '0;
          rx_n      = '0;
`ifdef SPIM_CS_GUARD_EN
          state_n   = SETUP;
          mosi_n    = 1'b0;
`else
          // First low phase begins on the cycle cs falls, so the first
          // bit must already be on mosi.
          state_n   = SHIFT;
          mosi_n    = addr[6];
`endif
        end
      end

`ifdef SPIM_CS_GUARD_EN
      SETUP: begin
        cnt_n = cnt + 9'd1;
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = SHIFT;
          mosi_n  = tx[15];
        end
      end

      HOLD: begin
        cnt_n = cnt + 9'd1;
        if (cnt == HALF_LAST) fin = 1'b1;
      end
`endif

      SHIFT: begin
        cnt_n = cnt + 9'd1;
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!sclk_pin) begin
            sclk_n = 1'b1;
          end else begin
            // Last clk of the high phase: sample the data byte on reads.
            if (rd && bit_cnt[3]) rx_n = {rx[6:0], miso_pin};
            sclk_n = 1'b0;
            if (bit_cnt == 4'd15) begin
`ifdef SPIM_CS_GUARD_EN
              state_n = HOLD;
              mosi_n  = 1'b0;
`else
              fin = 1'b1;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
              tx_n      = {tx[14:0], 1'b0};
              mosi_n    = tx[14];
            end
          end
        end
      end

      GAP: begin
        cnt_n = cnt + 9'd1;
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase

    // Frame end: release cs, pulse done and publish the read byte together.
    if (fin) begin
      state_n = GAP;
      cnt_n   = '0;
      sclk_n  = 1'b0;
      cs_n    = 1'b1;
      mosi_n  = 1'b0;
      done_n  = 1'b1;
      if (rd) rdata_n = rx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      rd       <= 1'b0;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx       <= tx_n;
      rx       <= rx_n;
      rd       <= rd_n;
      sclk_pin <= sclk_n;
      cs_pin   <= cs_n;
      mosi_pin <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
      rdata    <= rdata_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master with CLK_DIV=4. Build with
// SPIM_CS_GUARD_EN defined to exercise the SETUP/HOLD variant.
module tb_spi_master;

  localparam int DIV = 4;
`ifdef SPIM_CS_GUARD_EN
  localparam int FRAME   = 34 * DIV;
  localparam int RISE_OF = 2 * DIV;
`else
  localparam int FRAME   = 32 * DIV;
  localparam int RISE_OF = DIV;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;
  logic       miso = 1'b0;

  spi_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .miso_pin(miso)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: cycle count, cs edges, cs-low cycles, done pulses.
  int   cyc = 0;
  int   cs_low = 0, done_cnt = 0;
  int   fall_cyc = 0, rise_cyc = 0, gap = 0, rise_off = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0, armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cs_prev   <= cs_pin;
    sclk_prev <= sclk_pin;
    if (!cs_pin) cs_low <= cs_low + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (cs_prev && !cs_pin) begin
      fall_cyc <= cyc;
      gap      <= cyc - rise_cyc;
      armed    <= 1'b1;
    end
    if (!cs_prev && cs_pin) rise_cyc <= cyc;
    if (armed && sclk_pin && !sclk_prev) begin
      rise_off <= cyc - fall_cyc;
      armed    <= 1'b0;
    end
  end

  // Slave model: captures mosi on sclk rise, drives miso on sclk fall
  // during bits 8..15 of a read.
  int          rises = 0;
  logic [15:0] mosi_cap = '0;
  logic        slv_en = 1'b0;
  logic [7:0]  slv_byte = '0;

  always @(posedge sclk_pin or posedge cs_pin) begin
    if (cs_pin) rises <= 0;
    else begin
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[14:0], mosi_pin};
    end
  end

  always @(negedge sclk_pin)
    if (slv_en && rises >= 8 && rises < 16) miso <= slv_byte[15 - rises];

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] w,
                           input string tag);
    int bl, bd, n;
    logic [15:0] exp_frame;
    exp_frame = {a, r, (r ? 8'h00 : w)};
    @(negedge clk);
    bl = cs_low; bd = done_cnt;
    rw = r; addr = a; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_up"}, 32'(busy), 32'd1);
    chk({tag, "_cs_fall"}, 32'(cs_pin), 32'd0);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
    @(negedge clk); @(negedge clk);
    chk({tag, "_cs_low"}, 32'(cs_low - bl), 32'(FRAME));
    chk({tag, "_done_cnt"}, 32'(done_cnt - bd), 32'd1);
    chk({tag, "_mosi"}, 32'(mosi_cap), 32'(exp_frame));
    chk({tag, "_rise_off"}, 32'(rise_off), 32'(RISE_OF));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, bl, n;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs_pin), 32'd1);
    chk("rst_sclk", 32'(sclk_pin), 32'd0);
    chk("rst_mosi", 32'(mosi_pin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write 0xA5 to 0x15: command 0x2A, rdata untouched.
    run_frame(1'b0, 7'h15, 8'hA5, "wr");
    chk("wr_rdata", 32'(rdata), 32'h00);

    // Read from 0x15 with slave returning 0x3C: command 0x2B.
    slv_byte = 8'h3C; slv_en = 1'b1;
    run_frame(1'b1, 7'h15, 8'hFF, "rd");
    slv_en = 1'b0;
    chk("rd_rdata", 32'(rdata), 32'h3C);

    // A write must not disturb the held read byte.
    run_frame(1'b0, 7'h7F, 8'h00, "wr2");
    chk("wr2_rdata", 32'(rdata), 32'h3C);

    // start held high through two frames.
    @(negedge clk);
    bd = done_cnt; bl = cs_low;
    rw = 1'b0; addr = 7'h55; wdata = 8'h0F; start = 1'b1;
    n = 0;
    while ((done_cnt - bd) < 2 && n < 1000) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("b2b_timeout", 32'(n < 1000), 32'd1);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    chk("b2b_done_cnt", 32'(done_cnt - bd), 32'd2);
    chk("b2b_cs_low", 32'(cs_low - bl), 32'(2 * FRAME));
    chk("b2b_gap", 32'(gap), 32'(2 * DIV + 1));
    chk("b2b_mosi", 32'(mosi_cap), 32'hAA0F);

    // Reset 40 cycles into a write frame.
    @(negedge clk);
    rw = 1'b0; addr = 7'h33; wdata = 8'h81; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_cs_low", 32'(cs_pin), 32'd0);
    bd = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs", 32'(cs_pin), 32'd1);
    chk("mid_rst_sclk", 32'(sclk_pin), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_nodone", 32'(done_cnt - bd), 32'd0);
    run_frame(1'b0, 7'h33, 8'h81, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning clk cycles per sclk half-period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single FPGA clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a transaction request sampled in IDLE.
REQ-005 SHALL have port rw, input, 1, transaction type: 1 = read, 0 = write; captured with start.
REQ-006 SHALL have port addr, input, 7, target memory address; captured with start.
REQ-007 SHALL have port wdata, input, 8, write data; captured with start.
REQ-008 SHALL have port busy, output, 1, high while a transaction or the post-frame gap is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse at frame completion.
REQ-010 SHALL have port rdata, output, 8, the last read result.
REQ-011 SHALL have port sclk_pin, output, 1, the SPI clock.
REQ-012 SHALL have port cs_pin, output, 1, the SPI chip select (active-low).
REQ-013 SHALL have port mosi_pin, output, 1, master-out data.
REQ-014 SHALL have port miso_pin, input, 1, slave-out data; high-Z when the slave is not driving, so a sampled value may be X.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP; SETUP and HOLD exist only when SPIM_CS_GUARD_EN is defined.
REQ-016 SHALL, in IDLE with start=1, capture rw, addr and wdata and set busy=1 and cs_pin=0 on the next cycle; start is ignored in every other state.
REQ-017 SHALL build the frame as 16 bits sent MSB first: command byte {addr[6:0], rw}, followed by the data byte (wdata for a write, don't-care 0x00 on mosi for a read).
REQ-018 SHALL form each bit period from 2*CLK_DIV cycles: sclk_pin low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-019 SHALL update mosi_pin on the first cycle of each low phase, so mosi is stable across the rising edge at which the slave samples.
REQ-020 SHALL, for a read, sample miso_pin on the last clk of each high phase of bits 8..15 and shift it in MSB first.
REQ-021 SHALL transfer the assembled byte to rdata at frame end and hold it there until the next read completes; rdata is unchanged by writes.
REQ-022 SHALL, after the 16th high phase, drive sclk_pin=0, cs_pin=1 and mosi_pin=0, and pulse done=1 in that same cycle.
REQ-023 SHALL then enter GAP, holding cs_pin high for 2*CLK_DIV cycles with busy=1, and return to IDLE with busy=0, so the slave always observes cs deasserted between frames.
REQ-024 SHALL keep the frame at exactly 32*CLK_DIV cycles of cs_pin low when the guard is disabled.
REQ-025 SHALL accept start=1 on the first IDLE cycle after GAP, allowing back-to-back transactions.

Reset
REQ-026 SHALL, on reset=1 at a clk edge and in any state including mid-frame, enter IDLE and set sclk_pin=0, cs_pin=1, mosi_pin=0, busy=0, done=0, rdata=0x00 and clear all counters.
REQ-027 SHALL give reset priority over start in the same cycle.

Configuration
REQ-028 SHALL, when SPIM_CS_GUARD_EN is defined, insert SETUP (CLK_DIV cycles, cs_pin low, sclk_pin low) before the first bit and HOLD (CLK_DIV cycles, cs_pin low, sclk_pin low) after the 16th high phase, for a frame of 34*CLK_DIV cycles of cs low.
REQ-029 SHALL, when SPIM_CS_GUARD_EN is not defined, omit SETUP and HOLD, with the first low phase starting on the cycle cs_pin falls.

Verification (CLK_DIV=4, guard off unless stated)
REQ-030 SHALL cover a write: start with rw=0, addr=0x15, wdata=0xA5 -> mosi bits 0x2A then 0xA5 captured on the 16 sclk rising edges, cs_pin low for exactly 128 cycles, done pulse of one cycle, rdata stays 0x00.
REQ-031 SHALL cover a read: start with rw=1, addr=0x15, and a slave model driving 0x3C MSB first (changing on sclk falling edges) during bits 8..15 -> command 0x2B on mosi and rdata=0x3C at done.
REQ-032 SHALL cover start held high continuously for two frames -> second cs_pin fall exactly 8 cycles plus one IDLE cycle after the first cs_pin rise, and start ignored while busy.
REQ-033 SHALL cover reset asserted 40 cycles into a frame -> next cycle shows cs_pin=1, sclk_pin=0, busy=0, no done pulse, and a subsequent write completes normally.
REQ-034 SHALL cover the macro: with SPIM_CS_GUARD_EN defined, repeat REQ-030 -> first sclk rise 8 cycles after cs_pin falls, cs_pin low for 136 cycles, same mosi bit sequence.
